// File: rtl/keystat_fade_sched.sv
// rtl/keystat_fade_sched.sv - canvas bus owner with a periodic keystat BRGHT fade sweep
// Optional FADE_SKIP_IDLE_EN: registers the fade leaves unchanged are not written back.
`timescale 1ns/1ps
module keystat_fade_sched #(
  parameter int unsigned FADE_DIV  = 2,
  parameter logic [5:0]  KEY_FIRST = 6'h05,
  parameter logic [5:0]  KEY_LAST  = 6'h37
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       h_cs,
  input  logic       h_rden,
  input  logic       h_wren,
  input  logic [5:0] h_addr,
  input  logic [7:0] h_wdata,
  output logic [7:0] h_rdata,
  output logic       h_waitreq,
  output logic       c_cs,
  output logic       c_rden,
  output logic       c_wren,
  output logic [5:0] c_addr,
  output logic [7:0] c_wdata,
  input  logic [7:0] c_rdata,
  output logic       busy,
  output logic       missed
);

  localparam logic [5:0] CLR_ADDR = 6'h3F;
  localparam logic [3:0] DIV_LAST = 4'(FADE_DIV - 1);

  // The per-register "next" decision is folded into the exit of WR (or WAIT when
  // skipping), so one register costs ARM+RD+WAIT+WR = 4 cycles.
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RD, S_WAIT, S_WR} state_t;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] old_q, old_d;
  logic [3:0] frm_q, frm_d;
  logic       missed_q, missed_d;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic       tick, req, lock, advance, host_clr;

  function automatic logic [7:0] fade(input logic [7:0] v);
    logic [2:0] br;
    logic [1:0] co;
    logic [2:0] ns;
    br = v[7:5];
    co = v[4:3];
    ns = v[2:0];
    if ((ns != 3'd0 && co == 2'd0) || br == 3'd0)
      fade = v;
    else if (br == 3'd1 && co != 2'd0)
      fade = 8'h00;
    else
      fade = {br - 3'd1, co, ns};
  endfunction

  // vs idles high, so the sync chain resets high to avoid a phantom tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_s3_q <= 1'b1;
    end else begin
      vs_s1_q <= vs;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
    end
  end

  assign tick = vs_s3_q & ~vs_s2_q;

  always_comb begin
    frm_d = frm_q;
    req   = 1'b0;
    if (tick) begin
      if (frm_q == DIV_LAST) begin
        frm_d = 4'd0;
        req   = 1'b1;
      end else begin
        frm_d = frm_q + 4'd1;
      end
    end
  end

  assign lock     = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR);
  assign busy     = (state_q != S_IDLE);
  assign missed   = missed_q;
  assign h_rdata  = c_rdata;
  assign host_clr = h_cs & h_wren & ~h_waitreq & (h_addr == CLR_ADDR);

  always_comb begin
    missed_d = missed_q;
    if (host_clr)
      missed_d = 1'b0;
    if (req && busy)
      missed_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    old_d   = old_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_ARM;
          idx_d   = KEY_FIRST;
        end
      end
      S_ARM: begin
        if (!h_cs)
          state_d = S_RD;
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        old_d = c_rdata;
`ifdef FADE_SKIP_IDLE_EN
        if (fade(c_rdata) == c_rdata)
          advance = 1'b1;
        else
          state_d = S_WR;
`else
        state_d = S_WR;
`endif
      end
      S_WR: advance = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (idx_q == KEY_LAST) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + 6'd1;
        state_d = S_ARM;
      end
    end
  end

  // Host owns the canvas port except during the three locked RMW cycles.
  always_comb begin
    c_cs      = h_cs;
    c_rden    = h_rden;
    c_wren    = h_wren;
    c_addr    = h_addr;
    c_wdata   = h_wdata;
    h_waitreq = 1'b0;
    if (lock) begin
      c_cs      = (state_q != S_WAIT);
      c_rden    = (state_q == S_RD);
      c_wren    = (state_q == S_WR);
      c_addr    = idx_q;
      c_wdata   = (state_q == S_WR) ? fade(old_q) : 8'h00;
      h_waitreq = h_cs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= KEY_FIRST;
      old_q    <= 8'h00;
      frm_q    <= 4'd0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      old_q    <= old_d;
      frm_q    <= frm_d;
      missed_q <= missed_d;
    end
  end

endmodule

// File: tb/tb_keystat_fade_sched.sv
// tb/tb_keystat_fade_sched.sv - scoreboard bench for keystat_fade_sched
`timescale 1ns/1ps
module tb_keystat_fade_sched;

  localparam int FADE_DIV = 2;
`ifdef FADE_SKIP_IDLE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, vs, h_cs, h_rden, h_wren;
  logic [5:0] h_addr;
  logic [7:0] h_wdata;
  logic [7:0] h_rdata;
  logic       h_waitreq, c_cs, c_rden, c_wren, busy, missed;
  logic [5:0] c_addr;
  logic [7:0] c_wdata;
  logic [7:0] c_rdata;

  keystat_fade_sched #(.FADE_DIV(FADE_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .vs(vs),
    .h_cs(h_cs), .h_rden(h_rden), .h_wren(h_wren),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_waitreq(h_waitreq),
    .c_cs(c_cs), .c_rden(c_rden), .c_wren(c_wren),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata),
    .busy(busy), .missed(missed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int busy_cyc = 0;
  logic [7:0] canvas [64];
  logic [7:0] ref_mem [64];
  logic [7:0] wlog [$];
  logic [7:0] expq [$];
  logic [5:0] expa [$];
  logic       rd_pend = 1'b0;

  // Canvas register slave: read data appears one cycle after c_rden.
  always @(posedge clk) begin
    if (c_cs && c_wren) begin
      canvas[c_addr] <= c_wdata;
      if (busy) wr_cnt++;
      if (c_addr == 6'h0A) wlog.push_back(c_wdata);
    end
    if (c_cs && c_rden) begin
      c_rdata <= canvas[c_addr];
      if (busy) rd_cnt++;
    end
  end

  always @(negedge clk) if (busy) busy_cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Reference decay rule on the decimal fields of a keystat byte.
  function automatic logic [7:0] ref_fade(input logic [7:0] v);
    int bright, color, size;
    bright = int'(v) / 32;
    color  = (int'(v) / 8) % 4;
    size   = int'(v) % 8;
    if (bright == 0) return v;
    if (size > 0 && color == 0) return v;
    if (bright == 1 && color != 0) return 8'h00;
    return v - 8'd32;
  endfunction

  task automatic apply_ref_fade();
    for (int a = 5; a <= 55; a++) ref_mem[a] = ref_fade(ref_mem[a]);
  endtask

  task automatic do_hs(output int stalls);
    logic st;
    bit   done;
    stalls = 0;
    done = 1'b0;
    while (!done && stalls <= 20) begin
      #1 st = h_waitreq;
      @(posedge clk);
      if (!st) done = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL hs_timeout: got stalled expected accept within 20 cycles");
    end
  endtask

  task automatic host_idle();
    @(negedge clk);
    h_cs = 1'b0; h_rden = 1'b0; h_wren = 1'b0;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    int s;
    @(negedge clk);
    h_cs = 1'b1; h_wren = 1'b1; h_addr = a; h_wdata = d;
    do_hs(s);
    ref_mem[a] = d;
    host_idle();
  endtask

  task automatic host_read_exp(input logic [5:0] a, input logic [7:0] e);
    int s;
    expa.push_back(a);
    expq.push_back(e);
    @(negedge clk);
    h_cs = 1'b1; h_rden = 1'b1; h_addr = a;
    do_hs(s);
    host_idle();
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) host_read_exp(6'(a), ref_mem[a]);
  endtask

  task automatic vs_tick();
    @(negedge clk) vs = 1'b0;
    repeat (4) @(negedge clk);
    vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      $display("FAIL sweep_timeout: got busy expected idle within 3000 cycles");
    end
  endtask

  task automatic sweep_check();
    int changed = 0;
    for (int a = 5; a <= 55; a++) if (ref_fade(ref_mem[a]) != ref_mem[a]) changed++;
    rd_cnt = 0; wr_cnt = 0; busy_cyc = 0;
    vs_tick();
    check("odd_tick_no_sweep", busy, 0);
    vs_tick();
    check("sweep_started", busy, 1);
    wait_idle();
    check("sweep_cycles", busy_cyc, SKIP ? (51 * 3 + changed) : 204);
    check("sweep_rden", rd_cnt, 51);
    check("sweep_wren", wr_cnt, SKIP ? changed : 51);
    check("sweep_missed", missed, 0);
    apply_ref_fade();
  endtask

  // Scoreboard monitor: a read accepted in one cycle is compared the next.
  initial begin
    logic [5:0] a;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rd_pend) begin
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_read: got %0h expected none", h_rdata);
        end else begin
          a = expa.pop_front();
          e = expq.pop_front();
          check($sformatf("rd_%02h", a), h_rdata, e);
        end
      end
      rd_pend = h_cs && h_rden && !h_waitreq && reset_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    reset_n = 1'b0; vs = 1'b1;
    h_cs = 1'b0; h_rden = 1'b0; h_wren = 1'b0; h_addr = 6'h00; h_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_c_cs", c_cs, 0);
    check("rst_c_rden", c_rden, 0);
    check("rst_c_wren", c_wren, 0);
    check("rst_c_addr", c_addr, 0);
    check("rst_c_wdata", c_wdata, 0);
    check("rst_waitreq", h_waitreq, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed, 0);
    @(negedge clk) reset_n = 1'b1;

    for (int a = 0; a < 64; a++) host_write(6'(a), 8'($urandom_range(0, 255)));
    host_write(6'h10, 8'hE0);
    host_write(6'h08, 8'h5B);
    host_write(6'h09, 8'hE5);
    read_all();

    for (int k = 0; k < 8; k++) begin
      sweep_check();
      host_read_exp(6'h10, (k < 6) ? 8'(224 - 32 * (k + 1)) : 8'h00);
      host_read_exp(6'h08, (k == 0) ? 8'h3B : 8'h00);
      host_read_exp(6'h09, 8'hE5);
      read_all();
    end

    // Host write lands on the register the engine is reading right now.
    host_write(6'h0A, 8'hA8);
    wlog.delete();
    vs_tick();
    vs_tick();
    n = 0;
    do begin
      @(negedge clk);
      #1 n++;
    end while (!(c_cs && c_rden && c_addr == 6'h0A) && n < 500);
    check("contend_found_rd", n < 500, 1);
    h_cs = 1'b1; h_wren = 1'b1; h_addr = 6'h0A; h_wdata = 8'h66;
    do_hs(s);
    host_idle();
    check("contend_stalls", s, 3);
    wait_idle();
    check("contend_wlog_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("contend_engine_wr", wlog[0], ref_fade(8'hA8));
      check("contend_host_wr", wlog[1], 8'h66);
    end
    apply_ref_fade();
    ref_mem[6'h0A] = 8'h66;
    read_all();

    // Frame ticks arriving while a sweep runs.
    vs_tick();
    vs_tick();
    check("missed_sweep_busy", busy, 1);
    vs_tick();
    check("missed_not_on_count", missed, 0);
    vs_tick();
    check("missed_set", missed, 1);
    wait_idle();
    check("missed_sticky", missed, 1);
    repeat (20) @(negedge clk);
    check("missed_not_queued", busy, 0);
    apply_ref_fade();
    host_write(6'h3F, 8'h5A);
    @(negedge clk);
    check("missed_cleared", missed, 0);
    host_read_exp(6'h3F, 8'h5A);
    read_all();

    for (int a = 5; a <= 55; a++) host_write(6'(a), 8'h00);
    sweep_check();
    read_all();

    for (int a = 5; a <= 55; a++) host_write(6'(a), 8'($urandom_range(0, 255)));
    sweep_check();
    read_all();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
